// File: rtl/rc_add_sub_32.sv
// rtl/rc_add_sub_32.sv - ripple-carry adder/subtractor with registered result and carry-out

// Single-bit full adder cell; the adder is a chain of these.
module rc_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_p;

    // Propagate term is shared between sum and carry.
    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

// Add/sub datapath: SnA=0 gives A+B, SnA=1 gives A-B as A + ~B + 1.
module rc_add_sub_32 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  SnA,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  CO
);

    logic [DATA_WIDTH-1:0] w_bm;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH:0]   w_carry;

    logic [DATA_WIDTH-1:0] r_y;
    logic                  r_co;

    // Subtract inverts B and injects the +1 through the carry-in of bit 0.
    assign w_bm       = B ^ {DATA_WIDTH{SnA}};
    assign w_carry[0] = SnA;

    // Carry ripples strictly from bit 0 upward; no lookahead.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_chain
        rc_full_adder u_fa (
            .i_a (A[gi]),
            .i_b (w_bm[gi]),
            .i_c (w_carry[gi]),
            .o_s (w_sum[gi]),
            .o_c (w_carry[gi+1])
        );
    end

    // Capture result and MSB carry each cycle; reset clears both.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_y  <= '0;
            r_co <= 1'b0;
        end else begin
            r_y  <= w_sum;
            r_co <= w_carry[DATA_WIDTH];
        end
    end

    assign Y  = r_y;
    assign CO = r_co;

endmodule

// File: tb/tb_rc_add_sub_32.sv
// tb/tb_rc_add_sub_32.sv - randomized and directed self-checking bench for rc_add_sub_32
`timescale 1ns/1ps

module tb_rc_add_sub_32;

    logic        CLK;
    logic        RST;
    logic [31:0] A;
    logic [31:0] B;
    logic        SnA;
    logic [31:0] Y;
    logic        CO;

    int n_cmp;
    int n_fail;

    logic [31:0] m_y;
    logic        m_co;
    logic        m_valid;

    rc_add_sub_32 #(.DATA_WIDTH(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .A   (A),
        .B   (B),
        .SnA (SnA),
        .Y   (Y),
        .CO  (CO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: arithmetic on a 33-bit sum, sampled at each rising edge.
    always @(posedge CLK) begin
        logic [32:0] t;
        if (!RST) begin
            m_y     = 32'h0;
            m_co    = 1'b0;
            m_valid = 1'b1;
        end else begin
            t = {1'b0, A} + {1'b0, (SnA ? ~B : B)} + {32'h0, SnA};
            m_y  = t[31:0];
            m_co = t[32];
        end
    end

    // Compare process: mid-cycle check of outputs against the model.
    always @(negedge CLK) begin
        if (m_valid) begin
            n_cmp++;
            if (Y !== m_y || CO !== m_co) begin
                n_fail++;
                $display("FAIL model t=%0t: got Y=%h CO=%b, want Y=%h CO=%b", $time, Y, CO, m_y, m_co);
            end
        end
    end

    task automatic drive(input logic rst, input logic sna, input logic [31:0] a, input logic [31:0] b);
        RST = rst;
        SnA = sna;
        A   = a;
        B   = b;
        @(posedge CLK);
        #2;
    endtask

    task automatic check_lit(input string name, input logic [31:0] ey, input logic eco);
        n_cmp++;
        if (Y !== ey || CO !== eco) begin
            n_fail++;
            $display("FAIL %s: got Y=%h CO=%b, want Y=%h CO=%b", name, Y, CO, ey, eco);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        m_valid = 1'b0;
        m_y     = 32'h0;
        m_co    = 1'b0;

        // Reset held two cycles with a live operand pair.
        drive(1'b0, 1'b0, 32'd5, 32'd7);
        check_lit("reset_1", 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'd5, 32'd7);
        check_lit("reset_2", 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'd5, 32'd7);
        check_lit("post_reset_add", 32'd12, 1'b0);

        // Back-to-back operations, one-cycle latency.
        drive(1'b1, 1'b0, 32'd23, 32'd28);
        check_lit("add_23_28", 32'd51, 1'b0);
        drive(1'b1, 1'b1, 32'd100, 32'd1);
        check_lit("sub_100_1", 32'd99, 1'b1);
        drive(1'b1, 1'b1, 32'h3FFFFFFF, 32'd1);
        check_lit("sub_3fff_1", 32'h3FFFFFFE, 1'b1);
        drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'd1);
        check_lit("sub_ffff_1", 32'hFFFFFFFE, 1'b1);
        drive(1'b1, 1'b1, 32'd100, 32'd1);
        check_lit("sub_100_1b", 32'd99, 1'b1);

        // Carry wrap through the full chain.
        drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'd1);
        check_lit("add_wrap", 32'h0, 1'b1);
        drive(1'b1, 1'b0, 32'h80000000, 32'h80000000);
        check_lit("add_msb", 32'h0, 1'b1);

        // Borrow and equal-operand subtracts.
        drive(1'b1, 1'b1, 32'd0, 32'd1);
        check_lit("sub_0_1", 32'hFFFFFFFF, 1'b0);
        drive(1'b1, 1'b1, 32'd5, 32'd5);
        check_lit("sub_5_5", 32'h0, 1'b1);
        drive(1'b1, 1'b1, 32'd0, 32'd0);
        check_lit("sub_0_0", 32'h0, 1'b1);
        drive(1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF);
        check_lit("sub_a_a", 32'h0, 1'b1);

        // Reset in the middle of an add stream.
        drive(1'b1, 1'b0, 32'd1, 32'd2);
        check_lit("stream_1", 32'd3, 1'b0);
        drive(1'b0, 1'b0, 32'd10, 32'd20);
        check_lit("stream_rst", 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'd40, 32'd2);
        check_lit("stream_resume", 32'd42, 1'b0);
        drive(1'b1, 1'b0, 32'hFFFFFFF0, 32'h20);
        check_lit("stream_carry", 32'h10, 1'b1);

        // Random traffic, biased toward extreme operands, with rare resets.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rr;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFFFFFF;
                1: rb = 32'hFFFFFFFF;
                2: rb = ra;
                3: ra = 32'h0;
                default: ;
            endcase
            rr = ($urandom_range(0, 127) != 0);
            drive(rr, 1'($urandom_range(0, 1)), ra, rb);
        end

        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rc_add_sub_32.md
Name: rc_add_sub_32

Overview:
- 32-bit ripple-carry adder/subtractor with registered outputs.
- Used as the integer add/sub datapath element feeding the ALU result mux.
- SnA selects the operation: 0 gives A+B, 1 gives A−B.
- The sum is formed by a chain of 1-bit full adders. Y and CO are captured on the clock edge.

Parameters:
- DATA_WIDTH, 32, operand/result width. The design is verified only at 32, but the ripple chain must be generated from this parameter.

Ports:
- CLK  input  1  system clock; rising-edge active
- RST  input  1  synchronous reset, active-low; sampled on rising CLK edge
- A  input  DATA_WIDTH  operand A (minuend for subtract)
- B  input  DATA_WIDTH  operand B (subtrahend for subtract)
- SnA  input  1  operation select: 0 = add, 1 = subtract
- Y  output  DATA_WIDTH  registered result
- CO  output  1  registered carry-out of the MSB full adder

Behaviour:
- Reset: on a rising CLK edge with RST=0, Y ← 0 and CO ← 0. Reset overrides any operation presented in that cycle.
- Datapath (combinational):
  - Bm[i] = B[i] XOR SnA.
  - c[0] = SnA.
  - Full adder i: s[i] = A[i]^Bm[i]^c[i]; c[i+1] = A[i]&Bm[i] | c[i]&(A[i]^Bm[i]).
  - Carry ripples from bit 0 to bit DATA_WIDTH−1. No lookahead.
- Register: on a rising CLK edge with RST=1, Y ← s[DATA_WIDTH−1:0] and CO ← c[DATA_WIDTH].
- Latency: exactly 1 cycle. Operands present before edge N appear on Y/CO after edge N.
- Throughput: one operation per cycle. No handshake, no stall, no enable.
- Arithmetic rules:
  - Result is modulo 2^DATA_WIDTH; operands may be read as signed or unsigned.
  - Add: CO=1 on unsigned overflow.
  - Subtract: CO = carry of A + ~B + 1. CO=1 means no borrow (A ≥ B unsigned); CO=0 means borrow (A < B unsigned).
  - No overflow (V) flag is produced by this block.
- Boundary cases:
  - 0xFFFFFFFF + 1 → Y=0, CO=1.
  - 0 − 1 → Y=0xFFFFFFFF, CO=0.
  - A − A → Y=0, CO=1.
  - 0 − 0 → Y=0, CO=1.
- SnA changing between cycles takes effect on the next edge only. There is no dependency on prior operations.
- Outputs hold their last value while inputs are idle. There are no X outputs after the first reset.

Test Plan:
- Reset: RST=0 for 2 cycles with A=5, B=7, SnA=0 → Y=0, CO=0. Release RST; on the next edge Y=12, CO=0.
- Basic add, subtract, and 1-cycle latency:
  - Cycle-by-cycle stimulus:
    - SnA=0, A=23, B=28
    - SnA=1, A=100, B=1
    - SnA=1, A=0x3FFFFFFF, B=1
    - SnA=1, A=0xFFFFFFFF, B=1
    - SnA=1, A=100, B=1
  - Required outputs, each one edge later:
    - Y=51, CO=0
    - Y=99, CO=1
    - Y=0x3FFFFFFE, CO=1
    - Y=0xFFFFFFFE, CO=1
    - Y=99, CO=1
- Carry wrap and full ripple:
  - SnA=0, A=0xFFFFFFFF, B=1 → Y=0x00000000, CO=1.
  - SnA=0, A=0x80000000, B=0x80000000 → Y=0, CO=1.
- Borrow:
  - SnA=1, A=0, B=1 → Y=0xFFFFFFFF, CO=0.
  - SnA=1, A=5, B=5 → Y=0, CO=1.
- Reset mid-stream: while issuing a sequence of adds, assert RST=0 for one cycle → Y=0, CO=0 on that edge. The next operand pair appears normally one cycle after RST returns to 1.
- Random: 10k random A, B, SnA, checked against a reference model of {CO,Y} = A + (B^{32{SnA}}) + SnA with a 1-cycle delay.
